// File: rtl/bg1_index_fetch.sv
// Background layer 1 index fetch: maps the VGA beam position (with a
// per-frame horizontal scroll) to a background index ROM address and
// returns the palette index three cycles later.
//
// Ports:
//   Clk             system clock, rising edge
//   Reset           synchronous active-high reset
//   DrawX, DrawY    current VGA column / row
//   vs              VGA vertical sync (active low); falling edge = frame boundary
//   scroll_en       advance scroll_x by scroll_step each frame
//   scroll_step     source pixels advanced per frame
//   scroll_load     request to load scroll_load_val at the next frame boundary
//   scroll_load_val requested scroll offset (wrapped once at IMG_W)
//   rom_addr        registered index ROM address
//   rom_data        ROM output, valid one cycle after rom_addr
//   index           palette index (0 outside the active area)
//   index_valid     index belongs to an active-area pixel
//   scroll_x        current horizontal scroll offset
module bg1_index_fetch #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        vs,
  input  logic        scroll_en,
  input  logic [2:0]  scroll_step,
  input  logic        scroll_load,
  input  logic [8:0]  scroll_load_val,
  output logic [16:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  index,
  output logic        index_valid,
  output logic [8:0]  scroll_x
);

  localparam logic [9:0] IMG_W10 = 10'(IMG_W);
  localparam logic [8:0] IMG_W9  = 9'(IMG_W);
  localparam logic [8:0] IMG_H9  = 9'(IMG_H);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t      state, state_next;
  logic        vs_q;
  logic        boundary;
  logic        load_pend;
  logic [8:0]  load_val;
  logic        act1, act2;

  logic        active;
  logic [9:0]  sx_sum;
  logic [9:0]  sx;
  logic [16:0] sy17;
  logic [16:0] row_base;
  logic [16:0] addr_next;
  logic [8:0]  step_sum;
  logic [8:0]  step_wrap;
  logic [8:0]  load_wrap;

  // Rows past the image height are also treated as inactive so a shorter
  // image never reads beyond its own rows; for the default size this is
  // identical to DrawY < 480.
  assign active = (DrawX < 10'd640) && (DrawY < 10'd480) && (DrawY[9:1] < IMG_H9);

  // Both operands are below IMG_W, so one conditional subtraction wraps.
  assign sx_sum = {1'b0, DrawX[9:1]} + {1'b0, scroll_x};
  assign sx     = (sx_sum >= IMG_W10) ? (sx_sum - IMG_W10) : sx_sum;
  assign sy17   = {8'd0, DrawY[9:1]};

  generate
    if (IMG_W == 320) begin : g_row_shift
      assign row_base = (sy17 << 8) + (sy17 << 6);
    end else begin : g_row_mul
      assign row_base = 17'(sy17 * IMG_W);
    end
  endgenerate

  assign addr_next = row_base + {7'd0, sx};

  // Stage 1 address, stage 2 valid follows the ROM read, stage 3 output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr    <= '0;
      act1        <= 1'b0;
      act2        <= 1'b0;
      index       <= '0;
      index_valid <= 1'b0;
    end else begin
      rom_addr    <= active ? addr_next : 17'd0;
      act1        <= active;
      act2        <= act1;
      index       <= act2 ? rom_data : 4'd0;
      index_valid <= act2;
    end
  end

  assign boundary = vs_q && !vs;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      vs_q  <= 1'b1;
    end else begin
      state <= state_next;
      vs_q  <= vs;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (boundary) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign step_sum  = scroll_x + {6'd0, scroll_step};
  assign step_wrap = (step_sum >= IMG_W9) ? (step_sum - IMG_W9) : step_sum;
  assign load_wrap = (load_val >= IMG_W9) ? (load_val - IMG_W9) : load_val;

  // A load arriving in the UPDATE cycle re-arms the pending flag after the
  // older pending value has been consumed, so it lands next frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scroll_x  <= '0;
      load_pend <= 1'b0;
      load_val  <= '0;
    end else begin
      if (state == UPDATE) begin
        if (load_pend) begin
          scroll_x  <= load_wrap;
          load_pend <= 1'b0;
        end else if (scroll_en) begin
          scroll_x <= step_wrap;
        end
      end
      if (scroll_load) begin
        load_pend <= 1'b1;
        load_val  <= scroll_load_val;
      end
    end
  end

endmodule

// File: doc/bg1_index_fetch.md
BG1_INDEX_FETCH -- requirements
Module: bg1_index_fetch

Interface
- REQ-001 SHALL have parameter IMG_W, default 320, meaning background image width in source pixels.
- REQ-002 SHALL have parameter IMG_H, default 240, meaning background image height in source pixels.
- REQ-003 SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
- REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port DrawX, input, 10, current VGA pixel column (0-799).
- REQ-006 SHALL have port DrawY, input, 10, current VGA pixel row (0-524).
- REQ-007 SHALL have port vs, input, 1, VGA vertical sync, active low.
- REQ-008 SHALL have port scroll_en, input, 1, enable per-frame horizontal scroll.
- REQ-009 SHALL have port scroll_step, input, 3, source pixels advanced per frame (0-7).
- REQ-010 SHALL have port scroll_load, input, 1, request to load scroll_load_val at the next frame boundary.
- REQ-011 SHALL have port scroll_load_val, input, 9, requested scroll offset.
- REQ-012 SHALL have port rom_addr, output, 17, registered address to the background index ROM.
- REQ-013 SHALL have port rom_data, input, 4, ROM output, valid exactly one cycle after rom_addr.
- REQ-014 SHALL have port index, output, 4, palette index for the downstream bg1 palette lookup.
- REQ-015 SHALL have port index_valid, output, 1, high when index corresponds to an active-area pixel.
- REQ-016 SHALL have port scroll_x, output, 9, current horizontal scroll offset (0 to IMG_W-1).

Function
- REQ-017 Pipeline: stage 1 registers rom_addr; stage 2 is the ROM read; stage 3 registers index and index_valid; index for DrawX/DrawY sampled at cycle N SHALL appear at cycle N+3.
- REQ-018 Active test: active = (DrawX < 640) and (DrawY < 480); active SHALL be delayed in lockstep with the address through all three stages.
- REQ-019 Source coordinates: sx = DrawX[9:1] + scroll_x; if sx >= IMG_W then sx = sx - IMG_W (single subtraction, always sufficient); sy = DrawY[9:1].
- REQ-020 Address: rom_addr = sy*IMG_W + sx, computed without a multiplier for the default width ((sy<<8)+(sy<<6)), truncated to 17 bits; max 76799.
- REQ-021 Inactive pixels: rom_addr SHALL be 0, and stage 3 SHALL output index = 0, index_valid = 0, regardless of rom_data.
- REQ-022 Frame boundary: vs registered each cycle; boundary = previous vs 1 and current vs 0 (falling edge), a one-cycle event.
- REQ-023 Scroll FSM states: IDLE (waiting for boundary) and UPDATE (one cycle applying new scroll_x), returning to IDLE; boundary in IDLE enters UPDATE.
- REQ-024 scroll_load SHALL be latched into a pending flag and value register whenever asserted; later assertions before the boundary overwrite the value.
- REQ-025 In UPDATE, priority: pending load first -> scroll_x = val, or val - IMG_W if val >= IMG_W; pending flag cleared; else if scroll_en -> scroll_x = (scroll_x + scroll_step) wrapped once at IMG_W; else unchanged.
- REQ-026 scroll_load asserted in the same cycle as UPDATE SHALL remain pending for the next frame, not be applied or lost.
- REQ-027 scroll_x SHALL change only in UPDATE, never mid-frame; scroll_step = 0 with scroll_en = 1 leaves scroll_x unchanged.

Reset
- REQ-028 On Reset: scroll_x = 0, FSM = IDLE, pending flag = 0, vs history register = 1, rom_addr = 0, index = 0, index_valid = 0, all pipeline valid bits = 0.
- REQ-029 Reset asserted mid-frame or mid-pipeline SHALL discard in-flight pixels; the first index_valid = 1 appears no earlier than 3 cycles after Reset deasserts with active coordinates.

Verification
- REQ-030 Reset, scroll_x = 0, DrawX = 2, DrawY = 2 -> rom_addr = 321 one cycle later; rom_data = 4'hA -> index = 4'hA, index_valid = 1 at cycle N+3.
- REQ-031 DrawX = 700, DrawY = 10, rom_data = 4'hF -> index = 0, index_valid = 0, rom_addr = 0.
- REQ-032 scroll_x = 318, scroll_en = 1, scroll_step = 5, vs 1->0 -> scroll_x = 3 after UPDATE; DrawX = 0, DrawY = 0 then -> rom_addr = 3.
- REQ-033 scroll_load = 1, scroll_load_val = 400 mid-frame, scroll_en = 1 -> scroll_x unchanged until boundary, then 80; no step added that frame.
- REQ-034 scroll_load asserted in the UPDATE cycle with value 10 -> applied at the following boundary, scroll_x = 10.
- REQ-035 Reset pulsed while pipeline holds valid pixels -> index_valid = 0 next cycle and scroll_x = 0.
